// File: rtl/fft_addr_sequencer.sv
// fft_addr_sequencer: load/process/drain/output phase machine and address generator
// for an in-place radix-2 DIT FFT working across two ping-pong sample banks.
module fft_addr_sequencer #(
  parameter int LOG2N    = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic             we_a,
  output logic             we_b,
  output logic             rd_bank,
  output logic             wr_bank,
  output logic [LOG2N-2:0] twiddle_addr,
  output logic [LOG2N-1:0] out_addr,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  localparam int W = 2 * LOG2N + 2;
  localparam logic [LOG2N-1:0] LAST       = '1;
  localparam logic [LOG2N-1:0] HALF_LAST  = LAST >> 1;
  localparam logic [LOG2N-1:0] DRAIN_LAST = LOG2N'(PIPE_LAT - 1);
  localparam logic [3:0]       LVL_LAST   = 4'(LOG2N - 1);
  localparam logic             RES_BANK   = 1'(LOG2N % 2);
  localparam logic [LOG2N-2:0] ONES       = '1;

  typedef enum logic [2:0] {IDLE, LOAD, PROC, DRAIN, OUT} state_t;

  state_t           state, state_n;
  logic [LOG2N-1:0] cnt, cnt_n, brev, ja, jb;
  logic [3:0]       lvl, lvl_n;
  logic [W-1:0]     dl [PIPE_LAT];
  logic [W-1:0]     tail, issue;

  genvar i;
  for (i = 0; i < LOG2N; i++) begin : g_brev
    assign brev[i] = cnt[LOG2N-1-i];
  end

  assign ja    = {cnt[LOG2N-2:0], 1'b0};
  assign jb    = {cnt[LOG2N-2:0], 1'b1};
  assign tail  = dl[PIPE_LAT-1];
  // Delay-line word: {we, bank, addr_a, addr_b}; reads are zero outside PROC.
  assign issue = {state == PROC, state == PROC && !lvl[0], rd_addr_a, rd_addr_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lvl   <= '0;
      for (int k = 0; k < PIPE_LAT; k++) dl[k] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lvl   <= lvl_n;
      dl[0] <= issue;
      for (int k = 1; k < PIPE_LAT; k++) dl[k] <= dl[k-1];
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    lvl_n        = lvl;
    rd_addr_a    = '0;
    rd_addr_b    = '0;
    twiddle_addr = '0;
    rd_bank      = 1'b0;
    wr_addr_a    = tail[W-3:LOG2N];
    wr_addr_b    = tail[LOG2N-1:0];
    we_a         = tail[W-1];
    we_b         = tail[W-1];
    wr_bank      = tail[W-2];
    out_addr     = '0;
    out_valid    = 1'b0;
    done         = 1'b0;
    busy         = state != IDLE;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        cnt_n   = '0;
        lvl_n   = '0;
      end
      LOAD: begin
        wr_addr_a = brev;
        we_a      = in_valid;
        wr_bank   = 1'b0;
        if (in_valid) begin
          cnt_n   = cnt + 1'b1;
          state_n = cnt == LAST ? PROC : LOAD;
        end
      end
      PROC: begin
        // Butterfly pair (2j, 2j+1) rotated left by the level index.
        rd_addr_a    = LOG2N'({ja, ja} << lvl >> LOG2N);
        rd_addr_b    = LOG2N'({jb, jb} << lvl >> LOG2N);
        twiddle_addr = cnt[LOG2N-2:0] & ~(ONES >> lvl);
        rd_bank      = lvl[0];
        cnt_n        = cnt == HALF_LAST ? '0 : cnt + 1'b1;
        state_n      = cnt == HALF_LAST ? DRAIN : PROC;
      end
      DRAIN: begin
        rd_bank = lvl[0];
        cnt_n   = cnt + 1'b1;
        if (cnt == DRAIN_LAST) begin
          cnt_n   = '0;
          state_n = lvl == LVL_LAST ? OUT : PROC;
          lvl_n   = lvl == LVL_LAST ? lvl : lvl + 4'd1;
        end
      end
      OUT: begin
        rd_bank   = RES_BANK;
        out_valid = 1'b1;
        out_addr  = cnt;
        if (out_ready) begin
          cnt_n   = cnt + 1'b1;
          done    = cnt == LAST;
          state_n = cnt == LAST ? IDLE : OUT;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fft_addr_sequencer.sv
// tb_fft_addr_sequencer: randomized frames checked against an arithmetic FFT schedule model,
// plus a small 8-point instance for the parametrised corner.
module tb_fft_addr_sequencer;
  localparam int L = 6, N = 64, H = 32, PL = 2;
  localparam int T = L * (H + PL);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, in_valid, out_ready;
  logic [L-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, out_addr;
  logic [L-2:0] twiddle_addr;
  logic we_a, we_b, rd_bank, wr_bank, out_valid, busy, done;

  logic s_start, s_in_valid, s_out_ready;
  logic [2:0] s_rd_addr_a, s_rd_addr_b, s_wr_addr_a, s_wr_addr_b, s_out_addr;
  logic [1:0] s_twiddle_addr;
  logic s_we_a, s_we_b, s_rd_bank, s_wr_bank, s_out_valid, s_busy, s_done;

  fft_addr_sequencer #(.LOG2N(L), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .out_ready(out_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .we_a(we_a), .we_b(we_b), .rd_bank(rd_bank), .wr_bank(wr_bank), .twiddle_addr(twiddle_addr),
    .out_addr(out_addr), .out_valid(out_valid), .busy(busy), .done(done));

  fft_addr_sequencer #(.LOG2N(3), .PIPE_LAT(1)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid), .out_ready(s_out_ready),
    .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b), .wr_addr_a(s_wr_addr_a), .wr_addr_b(s_wr_addr_b),
    .we_a(s_we_a), .we_b(s_we_b), .rd_bank(s_rd_bank), .wr_bank(s_wr_bank), .twiddle_addr(s_twiddle_addr),
    .out_addr(s_out_addr), .out_valid(s_out_valid), .busy(s_busy), .done(s_done));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int brev(input int x, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (x[i]) r |= 1 << (w - 1 - i);
    return r;
  endfunction

  function automatic int rotl(input int x, input int l);
    return ((x << l) | (x >> (L - l))) & (N - 1);
  endfunction

  function automatic int twid(input int j, input int l);
    return (j >> (L - 1 - l)) << (L - 1 - l);
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, {rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b}, 0);
    chk({tag, "_ctl"}, {twiddle_addr, out_addr, we_a, we_b, rd_bank, wr_bank, out_valid, busy, done}, 0);
    chk({tag, "_small"}, {s_rd_addr_a, s_rd_addr_b, s_wr_addr_a, s_wr_addr_b, s_twiddle_addr,
                          s_out_addr, s_we_a, s_we_b, s_rd_bank, s_wr_bank, s_out_valid, s_busy, s_done}, 0);
  endtask

  task automatic idle_hold(input string tag);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; start = 1'b0; out_ready = 1'b1;
      #1;
      chk({tag, "_we"}, we_a, 0);
      chk({tag, "_busy"}, busy, 0);
      step;
    end
    in_valid = 1'b0;
  endtask

  task automatic load_frame;
    int k = 0, cyc = 0;
    start = 1'b1;
    #1 chk("start_idle_busy", busy, 0);
    step;
    while (k < N && cyc < 1000) begin
      in_valid = ($urandom % 4) != 0;
      start = 1'($urandom % 2);
      #1;
      chk("load_we", we_a, in_valid);
      chk("load_busy", busy, 1);
      if (in_valid) begin
        chk("load_addr", wr_addr_a, brev(k, L));
        chk("load_bank", wr_bank, 0);
        if (k == 1) chk("load_pin1", wr_addr_a, 32);
        if (k == 3) chk("load_pin3", wr_addr_a, 48);
        if (k == 63) chk("load_pin63", wr_addr_a, 63);
      end
      step;
      if (in_valid) k++;
      cyc++;
    end
    chk("load_count", k, N);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic proc_frame(input int abort_at, output bit aborted);
    int ia[T], ib[T], bk[T];
    bit iv[T];
    aborted = 1'b0;
    for (int t = 0; t < T; t++) begin
      int l = t / (H + PL), r = t % (H + PL);
      in_valid = 1'($urandom % 2); out_ready = 1'($urandom % 2); start = 1'($urandom % 2);
      #1;
      iv[t] = r < H;
      if (iv[t]) begin
        ia[t] = rotl(2 * r, l); ib[t] = rotl(2 * r + 1, l); bk[t] = l & 1;
        chk("rd_a", rd_addr_a, ia[t]);
        chk("rd_b", rd_addr_b, ib[t]);
        chk("twiddle", twiddle_addr, twid(r, l));
        chk("rd_bank", rd_bank, bk[t]);
        if (l == 0 && r == 0) chk("pin_l0j0", {rd_addr_a, rd_addr_b}, {6'd0, 6'd1});
        if (l == 1 && r == 5) chk("pin_l1j5", {rd_addr_a, rd_addr_b}, {6'd20, 6'd22});
        if (l == 5 && r == 31) chk("pin_l5j31", {rd_addr_a, rd_addr_b}, {6'd31, 6'd63});
        if (l == 2 && r == 13) chk("pin_tw_l2j13", twiddle_addr, 8);
      end
      if (t >= PL && iv[t-PL]) begin
        chk("wb_we", {we_a, we_b}, 2'b11);
        chk("wb_a", wr_addr_a, ia[t-PL]);
        chk("wb_b", wr_addr_b, ib[t-PL]);
        chk("wb_bank", wr_bank, 1 - bk[t-PL]);
        if (t == PL) chk("pin_wb_first", {wr_addr_a, wr_addr_b}, {6'd0, 6'd1});
      end else chk("wb_idle", {we_a, we_b}, 0);
      chk("proc_busy", busy, 1);
      chk("proc_outv", out_valid, 0);
      if (t == abort_at) begin
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        @(negedge clk) reset = 1'b0;
        aborted = 1'b1;
        return;
      end
      step;
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
  endtask

  task automatic out_frame;
    int k = 0, cyc = 0;
    while (k < N && cyc < 2000) begin
      out_ready = 1'($urandom % 2);
      in_valid = 1'($urandom % 2);
      start = k == N - 1 ? 1'b1 : 1'($urandom % 2);
      #1;
      chk("out_valid", out_valid, 1);
      chk("out_addr", out_addr, k);
      chk("out_bank", rd_bank, 0);
      chk("out_we", we_a, 0);
      chk("out_done", done, out_ready && k == N - 1);
      step;
      if (out_ready) k++;
      cyc++;
    end
    chk("out_count", k, N);
    start = 1'b0; in_valid = 1'b0;
    #1;
    chk("end_busy", busy, 0);
    chk("end_outv", out_valid, 0);
    chk("end_done", done, 0);
    step;
    idle_hold("post_done");
  endtask

  initial begin
    int lit8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int cyc;
    bit ab;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s_start = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    #1 reset = 1'b1;
    #1 chk_zero("reset_state");
    @(negedge clk) reset = 1'b0;
    idle_hold("pre_start");
    load_frame; proc_frame(-1, ab); out_frame;
    load_frame; proc_frame($urandom_range(10, T - 10), ab);
    chk("abort_taken", ab, 1);
    idle_hold("after_reset");
    load_frame; proc_frame(-1, ab); out_frame;
    s_start = 1'b1;
    step;
    s_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s_in_valid = 1'b1;
      #1 chk("s_load", {s_we_a, s_wr_addr_a}, {1'b1, 3'(lit8[k])});
      step;
    end
    s_in_valid = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      #1 if (s_out_valid) break;
      step;
      cyc++;
    end
    chk("s_proc_cycles", cyc, 15);
    for (int k = 0; k < 8; k++) begin
      s_out_ready = 1'b1;
      #1;
      chk("s_out", {s_out_valid, s_out_addr, s_rd_bank}, {1'b1, 3'(k), 1'b1});
      chk("s_done", s_done, k == 7);
      step;
    end
    s_out_ready = 1'b0;
    #1 chk("s_end_busy", s_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
